// File: rtl/spi_burst_arbiter.sv
// Round-robin arbiter that turns two requesters' multi-byte bursts into
// byte-by-byte start/busy handshakes on a shared single-byte SPI master driver.
module spi_burst_arbiter #(
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [LEN_W-1:0] len0_bi,
  input  logic [LEN_W-1:0] len1_bi,
  input  logic [7:0]       tx0_data_bi,
  input  logic [7:0]       tx1_data_bi,
  output logic             tx0_rd_o,
  output logic             tx1_rd_o,
  output logic [1:0]       gnt_bo,
  output logic             rx_valid_o,
  output logic [7:0]       rx_data_bo,
  output logic             rx_id_o,
  output logic             done_o,
  output logic             error_o,
  output logic             drv_start_o,
  output logic [7:0]       drv_data_bo,
  input  logic             drv_busy_i,
  input  logic [7:0]       drv_data_bi
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP, DONE
  } state_t;

  state_t             state_q, state_d;
  logic               last_q;
  logic               owner_q, owner_d;
  logic [LEN_W-1:0]   rem_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [GAP_W-1:0]   gap_q;

  logic               pick;
  logic [LEN_W-1:0]   len_sel;
  logic               tmo_hit;
  logic               gap_end;

  logic [1:0]         gnt_d;
  logic [1:0]         tx_rd_d;
  logic               drv_start_d;
  logic               done_d;
  logic               error_d;
  logic               rx_valid_d;

  // The requester not served last wins a tie; a lone request always wins.
  assign pick    = (req0_i && req1_i) ? ~last_q : req1_i;
  assign len_sel = pick ? len1_bi : len0_bi;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign gap_end = (gap_q == GAP_W'(GAP_CYCLES - 1));
  assign owner_d = (state_q == IDLE) ? pick : owner_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // Never hand the driver over while it is still shifting a stale byte.
        if (!drv_busy_i && (req0_i || req1_i))
          state_d = (len_sel == '0) ? DONE : LOAD;
      end
      LOAD:      state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (drv_busy_i)   state_d = WAIT_DONE;
        else if (tmo_hit) state_d = DONE;
      end
      WAIT_DONE: begin
        if (!drv_busy_i) begin
          if (rem_q <= LEN_W'(1))   state_d = DONE;
          else if (GAP_CYCLES == 0) state_d = LOAD;
          else                      state_d = GAP;
        end else if (tmo_hit) begin
          state_d = DONE;
        end
      end
      GAP:     if (gap_end) state_d = LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    tx_rd_d     = '0;
    drv_start_d = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    rx_valid_d  = 1'b0;
    if (state_d inside {LOAD, START, WAIT_BUSY, WAIT_DONE, GAP})
      gnt_d = owner_d ? 2'b10 : 2'b01;
    if (state_d == LOAD)
      tx_rd_d = owner_d ? 2'b10 : 2'b01;
    drv_start_d = (state_d == START);
    rx_valid_d  = (state_q == WAIT_DONE) && !drv_busy_i;
    done_d      = (state_d == DONE);
    // Only a clean last byte reaches DONE without an error.
    error_d     = done_d && !rx_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gnt_bo      <= '0;
      tx0_rd_o    <= 1'b0;
      tx1_rd_o    <= 1'b0;
      drv_start_o <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      rx_valid_o  <= 1'b0;
    end else begin
      gnt_bo      <= gnt_d;
      tx0_rd_o    <= tx_rd_d[0];
      tx1_rd_o    <= tx_rd_d[1];
      drv_start_o <= drv_start_d;
      done_o      <= done_d;
      error_o     <= error_d;
      rx_valid_o  <= rx_valid_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      rem_q       <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      drv_data_bo <= '0;
      rx_data_bo  <= '0;
      rx_id_o     <= 1'b0;
    end else begin
      owner_q <= owner_d;
      if (state_q == DONE) last_q <= owner_q;

      if (state_q == IDLE && state_d != IDLE)
        rem_q <= len_sel;
      else if (rx_valid_d && rem_q != '0)
        rem_q <= rem_q - LEN_W'(1);

      // Saturating per-state watchdog, cleared on every state change.
      if ((state_q == WAIT_BUSY || state_q == WAIT_DONE) && state_d == state_q) begin
        if (tmo_q != '1) tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end

      if (state_q == GAP) gap_q <= gap_q + GAP_W'(1);
      else                gap_q <= '0;

      if (state_q == LOAD) drv_data_bo <= owner_q ? tx1_data_bi : tx0_data_bi;

      if (rx_valid_d) begin
        rx_data_bo <= drv_data_bi;
        rx_id_o    <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed bench for spi_burst_arbiter with a loopback model of the SPI byte driver.
module tb_spi_burst_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       req0_i, req1_i;
  logic [3:0] len0_bi, len1_bi;
  logic [7:0] tx0_data_bi, tx1_data_bi;
  logic       tx0_rd_o, tx1_rd_o;
  logic [1:0] gnt_bo;
  logic       rx_valid_o;
  logic [7:0] rx_data_bo;
  logic       rx_id_o;
  logic       done_o, error_o;
  logic       drv_start_o;
  logic [7:0] drv_data_bo;
  logic       drv_busy_i  = 1'b0;
  logic [7:0] drv_data_bi = 8'h00;

  always #5 clk_i = ~clk_i;

  spi_burst_arbiter #(.LEN_W(4), .GAP_CYCLES(2), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req0_i(req0_i), .req1_i(req1_i),
    .len0_bi(len0_bi), .len1_bi(len1_bi),
    .tx0_data_bi(tx0_data_bi), .tx1_data_bi(tx1_data_bi),
    .tx0_rd_o(tx0_rd_o), .tx1_rd_o(tx1_rd_o),
    .gnt_bo(gnt_bo),
    .rx_valid_o(rx_valid_o), .rx_data_bo(rx_data_bo), .rx_id_o(rx_id_o),
    .done_o(done_o), .error_o(error_o),
    .drv_start_o(drv_start_o), .drv_data_bo(drv_data_bo),
    .drv_busy_i(drv_busy_i), .drv_data_bi(drv_data_bi)
  );

  int total = 0;
  int bad   = 0;

  // Driver model: busy for 4 cycles after a start, then returns the byte it sent.
  int         drv_mode = 0;
  int         drv_cnt  = 0;
  logic [7:0] drv_sh   = 8'h00;
  always @(posedge clk_i) begin
    if (drv_busy_i) begin
      if (drv_cnt == 0) begin
        drv_busy_i  <= 1'b0;
        drv_data_bi <= drv_sh;
      end else begin
        drv_cnt <= drv_cnt - 1;
      end
    end else if (drv_start_o && drv_mode == 0) begin
      drv_busy_i <= 1'b1;
      drv_cnt    <= 3;
      drv_sh     <= drv_data_bo;
    end
  end

  // Per-requester tx byte streams, advanced by each pop strobe.
  logic [7:0] tx0_mem [64];
  logic [7:0] tx1_mem [64];
  int pops0 = 0;
  int pops1 = 0;
  assign tx0_data_bi = tx0_mem[pops0[5:0]];
  assign tx1_data_bi = tx1_mem[pops1[5:0]];
  always @(posedge clk_i) begin
    if (tx0_rd_o) pops0 <= pops0 + 1;
    if (tx1_rd_o) pops1 <= pops1 + 1;
  end

  int         starts = 0;
  int         dones  = 0;
  logic [8:0] rxq [$];
  logic [1:0] gntq [$];
  logic [1:0] gnt_prev = 2'b00;
  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1) begin
      if (drv_start_o) begin
        starts <= starts + 1;
        total++;
        assert (drv_busy_i === 1'b0) else begin
          bad++;
          $error("FAIL start_while_busy observed=%0b expected=0", drv_busy_i);
        end
      end
      if (done_o) dones <= dones + 1;
      if (rx_valid_o) rxq.push_back({rx_id_o, rx_data_bo});
      if (gnt_bo != 2'b00 && gnt_prev == 2'b00) gntq.push_back(gnt_bo);
    end
    gnt_prev <= gnt_bo;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done_o && cyc < budget);
    chk("done_seen", 32'(done_o), 1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({gnt_bo, tx0_rd_o, tx1_rd_o, rx_valid_o, rx_data_bo, rx_id_o,
                done_o, error_o, drv_start_o, drv_data_bo});
  endfunction

  initial begin
    int s, d, r, p0, p1, g, cyc, n;
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 64; i++) begin
      tx0_mem[i] = 8'h00;
      tx1_mem[i] = 8'h00;
    end
    rst_n_i = 1'b0;
    req0_i = 1'b0; req1_i = 1'b0;
    len0_bi = 4'd0; len1_bi = 4'd0;
    tick(); tick();
    chk("reset_outputs", all_outs(), 0);
    rst_n_i = 1'b1;
    tick();

    // Single burst of three bytes from requester 0
    p0 = pops0; p1 = pops1; s = starts; d = dones; r = rxq.size();
    tx0_mem[p0] = 8'hA5; tx0_mem[p0+1] = 8'h3C; tx0_mem[p0+2] = 8'hFF;
    len0_bi = 4'd3; req0_i = 1'b1;
    tick();
    chk("t1_gnt", 32'(gnt_bo), 32'h1);
    req0_i = 1'b0;
    wait_done(300, cyc);
    chk("t1_error", 32'(error_o), 0);
    tick();
    chk("t1_starts", 32'(starts - s), 3);
    chk("t1_rx_count", 32'(rxq.size() - r), 3);
    chk("t1_rx0", 32'(rxq[r]),   32'h0A5);
    chk("t1_rx1", 32'(rxq[r+1]), 32'h03C);
    chk("t1_rx2", 32'(rxq[r+2]), 32'h0FF);
    chk("t1_pops0", 32'(pops0 - p0), 3);
    chk("t1_pops1", 32'(pops1 - p1), 0);
    chk("t1_dones", 32'(dones - d), 1);

    // Simultaneous requests straight after reset: requester 0 first
    rst_n_i = 1'b0; tick(); rst_n_i = 1'b1; tick();
    p0 = pops0; p1 = pops1; d = dones; r = rxq.size();
    tx0_mem[p0] = 8'h11; tx0_mem[p0+1] = 8'h22;
    tx1_mem[p1] = 8'h33; tx1_mem[p1+1] = 8'h44;
    len0_bi = 4'd2; len1_bi = 4'd2; req0_i = 1'b1; req1_i = 1'b1;
    tick();
    chk("t2_gnt_first", 32'(gnt_bo), 32'h1);
    req0_i = 1'b0;
    wait_done(300, cyc);
    tick();
    chk("t2_gnt_idle", 32'(gnt_bo), 0);
    tick();
    chk("t2_gnt_second", 32'(gnt_bo), 32'h2);
    req1_i = 1'b0;
    wait_done(300, cyc);
    tick();
    chk("t2_rx_count", 32'(rxq.size() - r), 4);
    chk("t2_rx0", 32'(rxq[r]),   32'h011);
    chk("t2_rx1", 32'(rxq[r+1]), 32'h022);
    chk("t2_rx2", 32'(rxq[r+2]), 32'h133);
    chk("t2_rx3", 32'(rxq[r+3]), 32'h144);
    chk("t2_dones", 32'(dones - d), 2);

    // Both held with len=1: grants alternate
    g = gntq.size(); d = dones;
    len0_bi = 4'd1; len1_bi = 4'd1; req0_i = 1'b1; req1_i = 1'b1;
    for (int i = 0; i < 4; i++) wait_done(300, cyc);
    req0_i = 1'b0; req1_i = 1'b0;
    tick();
    chk("t3_grants", 32'(gntq.size() - g), 4);
    for (int i = 0; i < 4; i++) chk("t3_gnt_order", 32'(gntq[g+i]), 32'(exp_g[i]));
    chk("t3_dones", 32'(dones - d), 4);

    // Driver never answers busy: watchdog aborts
    drv_mode = 1;
    s = starts; r = rxq.size();
    len1_bi = 4'd1; req1_i = 1'b1;
    tick();
    chk("t4_gnt", 32'(gnt_bo), 32'h2);
    req1_i = 1'b0;
    wait_done(300, cyc);
    chk("t4_latency", 32'(cyc), 66);
    chk("t4_error", 32'(error_o), 1);
    chk("t4_gnt_released", 32'(gnt_bo), 0);
    tick();
    chk("t4_no_rx", 32'(rxq.size() - r), 0);
    chk("t4_starts", 32'(starts - s), 1);
    drv_mode = 0;

    // Zero-length request
    s = starts; p0 = pops0;
    len0_bi = 4'd0; req0_i = 1'b1;
    wait_done(10, cyc);
    chk("t5_within_3", 32'(cyc <= 3), 1);
    chk("t5_error", 32'(error_o), 1);
    req0_i = 1'b0;
    tick();
    chk("t5_no_start", 32'(starts - s), 0);
    chk("t5_no_pop", 32'(pops0 - p0), 0);

    // Reset while the second of four bytes is in flight
    s = starts; p0 = pops0;
    for (int i = 0; i < 4; i++) tx0_mem[p0+i] = 8'(i + 1);
    len0_bi = 4'd4; req0_i = 1'b1;
    tick();
    req0_i = 1'b0;
    n = 0;
    while (starts - s < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("t6_reached_byte2", 32'(starts - s), 2);
    tick(); tick();
    chk("t6_busy_before_rst", 32'(drv_busy_i), 1);
    chk("t6_gnt_before_rst", 32'(gnt_bo), 32'h1);
    d = dones;
    rst_n_i = 1'b0;
    #1;
    chk("t6_outputs_in_rst", all_outs(), 0);
    repeat (10) tick();
    rst_n_i = 1'b1;
    tick();
    chk("t6_no_done", 32'(dones - d), 0);
    s = starts; p0 = pops0; r = rxq.size();
    for (int i = 0; i < 4; i++) tx0_mem[p0+i] = 8'(8'h91 + i);
    req0_i = 1'b1;
    tick();
    req0_i = 1'b0;
    wait_done(400, cyc);
    chk("t6_error", 32'(error_o), 0);
    tick();
    chk("t6_starts", 32'(starts - s), 4);
    chk("t6_pops", 32'(pops0 - p0), 4);
    chk("t6_rx_count", 32'(rxq.size() - r), 4);
    for (int i = 0; i < 4; i++) chk("t6_rx", 32'(rxq[r+i]), 32'(8'h91 + i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_burst_arbiter.md
Name: spi_burst_arbiter

Overview:
- Sequences multi-byte SPI bursts through the single-byte SPI master driver (CPOL=0, CPHA=0): pulses its start, waits for its busy handshake and collects each received byte.
- Shares that one driver between two requesters using round-robin arbitration.
- Each granted burst runs to completion before the driver is re-arbitrated.
- Sits between the system-side requesters and the SPI master driver.

Parameters:
- LEN_W, 4, width of burst length inputs; legal lengths 1..2^LEN_W-1 bytes.
- GAP_CYCLES, 2, idle clk_i cycles inserted between consecutive bytes of one burst (0 allowed).
- TIMEOUT, 64, max clk_i cycles spent in WAIT_BUSY or in WAIT_DONE before the burst is aborted.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous, active-low reset
- req0_i / req1_i  in  1  burst request, level; sampled only in IDLE
- len0_bi / len1_bi  in  LEN_W  burst byte count, sampled at grant
- tx0_data_bi / tx1_data_bi  in  8  current tx byte, valid whenever the matching req is high
- tx0_rd_o / tx1_rd_o  out  1  one-cycle pop strobe; tx byte captured in that cycle
- gnt_bo  out  2  one-hot grant, held for the whole burst
- rx_valid_o  out  1  one-cycle strobe, rx byte available
- rx_data_bo  out  8  received byte
- rx_id_o  out  1  index of the requester owning rx_data_bo
- done_o  out  1  one-cycle strobe at burst end
- error_o  out  1  asserted together with done_o on timeout or len=0
- drv_start_o  out  1  to driver start
- drv_data_bo  out  8  to driver data in
- drv_busy_i  in  1  from driver busy
- drv_data_bi  in  8  from driver data out

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - all outputs 0; state IDLE; round-robin pointer favours requester 0.
  - Mid-burst reset aborts immediately; no done_o is generated.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP, DONE.
- IDLE:
  - if any req is high, grant goes to the requester not served last (the pointer resolves simultaneous requests).
  - gnt_bo is registered next cycle, len is latched into a remaining counter, and the FSM goes to LOAD.
  - len=0 goes to DONE with error_o=1 and no SPI traffic.
- LOAD: the granted txK_rd_o is 1 for one cycle and tx_data is latched; go to START.
- START:
  - drv_start_o=1 for exactly one cycle; drv_data_bo = latched byte, held stable until the next LOAD.
  - Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - drv_busy_i=1 goes to WAIT_DONE and clears the timeout counter.
  - Timeout reached goes to DONE with error.
- WAIT_DONE:
  - drv_busy_i=0 captures drv_data_bi into rx_data_bo; rx_valid_o=1 and rx_id_o=K in the next cycle.
  - remaining is decremented.
  - If remaining becomes 0, go to DONE; else go to GAP (or LOAD when GAP_CYCLES=0).
  - Timeout goes to DONE with error; the partial byte is discarded.
- GAP: count GAP_CYCLES cycles, then go to LOAD.
- DONE:
  - done_o=1 (and error_o if flagged) for one cycle.
  - gnt_bo is cleared in the same cycle; the pointer marks K as last served; return to IDLE.
- A new grant is possible at the earliest one cycle after DONE.
- Req deassertion mid-burst is ignored; the burst completes with the latched length.
- Timeout counter saturates; it is active only in WAIT_BUSY/WAIT_DONE.
- Exactly one drv_start_o pulse per byte; a start is never issued while drv_busy_i=1.
- The remaining counter is LEN_W wide with no wrap: decrement happens only when remaining is nonzero.

Test Plan:
- Single burst: req0=1, len0=3, tx bytes 0xA5,0x3C,0xFF, slave loopback → 3 drv_start_o pulses, rx 0xA5,0x3C,0xFF with rx_id_o=0, one done_o, error_o=0, tx0_rd_o pulsed 3×.
- Contention: req0 and req1 asserted in the same cycle after reset, len=2 each → requester 0 bursts first; gnt_bo=01 then 10; no interleaved bytes; 2 done_o strobes.
- Fairness: req0 held permanently with len=1, req1 asserted → grants alternate 0,1,0,1 over 4 bursts.
- Timeout: drv_busy_i tied 0, req1=1, len=1 → after 64 cycles in WAIT_BUSY, done_o=error_o=1, no rx_valid_o, gnt released.
- len=0: req0=1, len0=0 → done_o=error_o=1 within 3 cycles, no drv_start_o, no tx0_rd_o.
- Reset mid-burst: rst_n_i low during WAIT_DONE of byte 2 of 4 → all outputs 0 immediately; after release, a fresh req0 burst runs normally from byte 1.
